level_store: RTL

LEVEL_STORE -- requirements
Module: level_store

---
 rtl/level_store_pkg.sv | 18 +
 rtl/level_store_mem.sv | 25 ++
 rtl/level_store.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/level_store_pkg.sv
// Shared types and defaults for the level store: controller states,
// read/write encoding and default geometry.
package level_store_pkg;

    localparam int DEFAULT_DEPTH  = 16;
    localparam int DEFAULT_ADDR_W = 8;
    localparam int DATA_W         = 8;

    localparam logic R_W_WRITE = 1'b1;
    localparam logic R_W_READ  = 1'b0;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/level_store_mem.sv
// Level storage: one synchronous write port, one combinational read port.
module level_store_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/level_store.sv
// Level store controller: clear sweep after reset, single-cycle response
// accesses, and a running maximum of written levels.
module level_store
    import level_store_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              r_w,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              ack,
    output logic              err,
    output logic              busy,
    output logic [DATA_W-1:0] max_level,
    output logic [ADDR_W-1:0] max_addr
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    sweep_q, sweep_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [DATA_W-1:0]   max_lvl_q, max_lvl_d;
    logic [ADDR_W-1:0]   max_addr_q, max_addr_d;

    logic                mem_we;
    logic [CNT_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic [CNT_W-1:0]    idx;
    logic                in_range;

    assign idx      = CNT_W'(address_in);
    assign in_range = 32'(address_in) < 32'(DEPTH);

    level_store_mem #(
        .DEPTH (DEPTH),
        .AW    (CNT_W),
        .DW    (DATA_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (idx),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        dout_d     = dout_q;
        max_lvl_d  = max_lvl_q;
        max_addr_d = max_addr_q;
        mem_we     = 1'b0;
        mem_waddr  = sweep_q;
        mem_wdata  = '0;

        unique case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                if (sweep_q == CNT_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    if (!in_range) begin
                        err_d  = 1'b1;
                        dout_d = '0;
                    end else if (r_w == R_W_WRITE) begin
                        mem_we    = 1'b1;
                        mem_waddr = idx;
                        mem_wdata = data_in;
                        if (data_in > max_lvl_q) begin
                            max_lvl_d  = data_in;
                            max_addr_d = address_in;
                        end
                    end else begin
                        dout_d = mem_rdata;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
                sweep_d = '0;
            end
        endcase

        // A reset edge must never commit a write for an aborted access.
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            sweep_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dout_q     <= '0;
            max_lvl_q  <= '0;
            max_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dout_q     <= dout_d;
            max_lvl_q  <= max_lvl_d;
            max_addr_q <= max_addr_d;
        end
    end

    // Reset raised during the response cycle suppresses the completion.
    assign ack       = ack_q & ~reset;
    assign err       = err_q & ~reset;
    assign busy      = (state_q == ST_CLEAR);
    assign data_out  = dout_q;
    assign max_level = max_lvl_q;
    assign max_addr  = max_addr_q;

endmodule
